state_monitor_scheduler: RTL

Shares one programmable hold-off (transient) timer across NUM_CH monitored input lines. Each line's level changes are synchronised and edge-detected, then held as pending requests. A round-robin arbiter grants one channel at a time to the shared timer. After the hold-off expires, the block re-samples the granted line and reports the settled level through a valid/ready event port. It sits between the raw ui_in pins and the LED/status output logic of the state-monitor top level.

---
 rtl/state_monitor_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/state_monitor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : state_monitor_scheduler
// Description : Shares one programmable hold-off timer across NUM_CH monitored
//               lines. Level changes are synchronised, edge-detected and held
//               as pending requests; a round-robin arbiter hands the timer to
//               one channel at a time. When the hold-off expires the granted
//               line is re-sampled and its settled level is reported on a
//               valid/ready event port.
// Options     : STATE_MON_OVERRUN_EN adds the 'overrun' output, which flags
//               transitions merged into an already-pending request.
// Revision    : 1.0 - initial release
// ============================================================================
module state_monitor_scheduler #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 18,
    parameter int SCALE  = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] mon_in,
    input  logic [3:0]        delay_sel,
    input  logic              enable,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_ch,
    output logic              evt_level,
    output logic [NUM_CH-1:0] stable_out,
    output logic              busy,
    output logic [NUM_CH-1:0] pending_out
`ifdef STATE_MON_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0] overrun
`endif
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPORT = 2'd2;

    // Arbitration starts from channel 0 after reset.
    localparam logic [2:0] c_LAST_RST  = 3'(NUM_CH - 1);

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] change;

    logic [1:0]        state_q,      state_d;
    logic [CNT_W-1:0]  timer_q,      timer_d;
    logic [NUM_CH-1:0] pending_q,    pending_d;
    logic [NUM_CH-1:0] stable_q,     stable_d;
    logic              evt_valid_q,  evt_valid_d;
    logic [2:0]        evt_ch_q,     evt_ch_d;
    logic              evt_level_q,  evt_level_d;
    logic [2:0]        last_grant_q, last_grant_d;

    logic [2:0]        winner;
    logic [2:0]        cand;
    logic              found;
    logic [NUM_CH-1:0] grant_clr;
    logic [CNT_W-1:0]  timer_load;
    logic              report_accept;

    // Two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= mon_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign change        = sync2_q ^ prev_q;
    assign timer_load    = CNT_W'(32'(delay_sel) * 32'(SCALE));
    assign report_accept = evt_valid_q & evt_ready;

    // Round-robin search: first pending bit above last_grant, wrapping.
    always_comb begin
        winner = last_grant_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = 3'((int'(last_grant_q) + k) % NUM_CH);
            if (!found && pending_q[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Scheduler FSM: grant in IDLE, count down in HOLD, handshake in REPORT.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        stable_d     = stable_q;
        evt_valid_d  = evt_valid_q;
        evt_ch_d     = evt_ch_q;
        evt_level_d  = evt_level_q;
        last_grant_d = last_grant_q;
        grant_clr    = '0;
        case (state_q)
            c_ST_IDLE: begin
                if (enable && (|pending_q)) begin
                    state_d      = c_ST_HOLD;
                    evt_ch_d     = winner;
                    last_grant_d = winner;
                    timer_d      = timer_load;
                    grant_clr    = NUM_CH'(1) << winner;
                end
            end
            c_ST_HOLD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    evt_level_d        = sync2_q[evt_ch_q];
                    stable_d[evt_ch_q] = sync2_q[evt_ch_q];
                    evt_valid_d        = 1'b1;
                    state_d            = c_ST_REPORT;
                end
            end
            c_ST_REPORT: begin
                if (report_accept) begin
                    evt_valid_d = 1'b0;
                    state_d     = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // A new edge always re-arms pending, even on the cycle it is granted.
    always_comb begin
        pending_d = (pending_q & ~grant_clr) | change;
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= c_ST_IDLE;
            timer_q      <= '0;
            pending_q    <= '0;
            stable_q     <= '0;
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
            evt_level_q  <= 1'b0;
            last_grant_q <= c_LAST_RST;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            stable_q     <= stable_d;
            evt_valid_q  <= evt_valid_d;
            evt_ch_q     <= evt_ch_d;
            evt_level_q  <= evt_level_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef STATE_MON_OVERRUN_EN
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] accept_clr;

    // A second edge on an ungranted pending channel means a lost transition;
    // the flag is released by the accepted report for that channel.
    always_comb begin
        accept_clr = report_accept ? (NUM_CH'(1) << evt_ch_q) : '0;
        overrun_d  = (overrun_q & ~accept_clr) | (change & pending_q & ~grant_clr);
    end

    // Overrun flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign evt_valid   = evt_valid_q;
    assign evt_ch      = evt_ch_q;
    assign evt_level   = evt_level_q;
    assign stable_out  = stable_q;
    assign busy        = (state_q == c_ST_HOLD) || (state_q == c_ST_REPORT);
    assign pending_out = pending_q;

endmodule
`default_nettype wire
